// File: rtl/bht_update_scheduler_pkg.sv
// Shared definitions for the branch history table update scheduler:
// FSM state encoding, 2-bit counter encodings and the saturating
// counter next-state function.
package bht_update_scheduler_pkg;

  // Scheduler FSM states
  localparam logic [1:0] ST_INIT = 2'd0;
  localparam logic [1:0] ST_IDLE = 2'd1;
  localparam logic [1:0] ST_RD   = 2'd2;
  localparam logic [1:0] ST_WR   = 2'd3;

  // 2-bit branch counter encodings
  typedef enum logic [1:0] {
    STRONG_NT = 2'b00,
    WEAK_NT   = 2'b01,
    WEAK_T    = 2'b10,
    STRONG_T  = 2'b11
  } ctr_e;

  // Saturating counter update: taken counts up to STRONG_T,
  // not-taken counts down to STRONG_NT.
  function automatic logic [1:0] ctr_next(input logic [1:0] cur, input logic taken);
    logic [1:0] nxt;
    if (taken) nxt = (cur == STRONG_T)  ? cur : cur + 2'd1;
    else       nxt = (cur == STRONG_NT) ? cur : cur - 2'd1;
    return nxt;
  endfunction

endpackage

// File: rtl/bht_upd_fifo.sv
// Synchronous FIFO holding resolved-branch updates {addr, taken} until
// the scheduler finds a free slot on the table port.
// With BHT_BYPASS_EN defined the storage, read pointer and occupancy are
// exported so the top can search pending updates at lookup time.
module bht_upd_fifo #(
  parameter  int DEPTH  = 4,
  parameter  int DATA_W = 9,
  localparam int PTR_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [DATA_W-1:0] rdata_o,
  output logic              full_o,
  output logic              empty_o
`ifdef BHT_BYPASS_EN
  ,
  output logic [DEPTH-1:0][DATA_W-1:0] mem_o,
  output logic [PTR_W-1:0]             rd_ptr_o,
  output logic [PTR_W:0]               count_o
`endif
);

  logic [DEPTH-1:0][DATA_W-1:0] mem_q;
  logic [PTR_W-1:0]             wr_ptr_q;
  logic [PTR_W-1:0]             rd_ptr_q;
  logic [PTR_W:0]               count_q;

  // Entry storage written at the tail on every push
  // NOTE: storage carries no reset; occupancy is tracked by count_q, so stale
  // entries are never observed and the array can map onto plain flops/LUTRAM.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  // Pointer and occupancy tracking; reset empties the queue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop_i)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({push_i, pop_i})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (count_q == '0);

`ifdef BHT_BYPASS_EN
  assign mem_o    = mem_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;
`endif

endmodule

// File: rtl/bht_update_scheduler.sv
// Owner of the single-port 2-bit branch history table. Fetch lookups get
// the port first; execute updates are queued and applied as
// read-modify-write (IDLE read, RD wait, WR write) in lookup-free cycles,
// or forcibly once the queue is full. After reset the whole table is
// swept to INIT_STATE before any traffic is accepted.
// Optional build macro: BHT_BYPASS_EN -- a lookup that hits a queued
// update reports the youngest queued direction in pred_taken.
module bht_update_scheduler
  import bht_update_scheduler_pkg::*;
#(
  parameter int         ADDR_W     = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [1:0] INIT_STATE = 2'b11
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              lk_valid,
  input  logic [ADDR_W-1:0] lk_addr,
  output logic              lk_ready,
  output logic              pred_valid,
  output logic              pred_taken,
  output logic [1:0]        pred_state,
  input  logic              upd_valid,
  input  logic [ADDR_W-1:0] upd_addr,
  input  logic              upd_taken,
  output logic              upd_ready,
  output logic              busy,
  output logic              tbl_en,
  output logic              tbl_we,
  output logic [ADDR_W-1:0] tbl_addr,
  output logic [1:0]        tbl_wdata,
  input  logic [1:0]        tbl_rdata
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        rmw_q;
  logic              pred_valid_q;

  logic              fifo_full, fifo_empty;
  logic [ADDR_W:0]   fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic              head_taken;
  logic              lk_fire, push, pop;

  logic              en_c, we_c;
  logic [ADDR_W-1:0] addr_c;
  logic [1:0]        wdata_c;

  assign head_addr  = fifo_head[ADDR_W:1];
  assign head_taken = fifo_head[0];

  // A full queue blocks lookups so the pending RMW always gets the port.
  assign lk_ready  = (state_q == ST_IDLE) && !fifo_full;
  assign lk_fire   = lk_valid && lk_ready;
  assign pop       = (state_q == ST_WR);
  // The WR pop frees a slot in the same cycle, so a full queue still accepts.
  assign upd_ready = (state_q != ST_INIT) && (!fifo_full || pop);
  assign push      = upd_valid && upd_ready;
  assign busy      = (state_q == ST_INIT);

`ifdef BHT_BYPASS_EN
  logic [FIFO_DEPTH-1:0][ADDR_W:0] fifo_mem;
  logic [PTR_W-1:0]                fifo_rd_ptr;
  logic [PTR_W:0]                  fifo_count;
`endif

  bht_upd_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (ADDR_W + 1)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_i   (push),
    .wdata_i  ({upd_addr, upd_taken}),
    .pop_i    (pop),
    .rdata_o  (fifo_head),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty)
`ifdef BHT_BYPASS_EN
    ,
    .mem_o    (fifo_mem),
    .rd_ptr_o (fifo_rd_ptr),
    .count_o  (fifo_count)
`endif
  );

  // Next-state and table-port selection for sweep, lookup and RMW
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // it unassigned, which would otherwise infer a latch.
    state_d = state_q;
    idx_d   = idx_q;
    en_c    = 1'b0;
    we_c    = 1'b0;
    addr_c  = '0;
    wdata_c = '0;
    case (state_q)
      ST_INIT: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = idx_q;
        wdata_c = INIT_STATE;
        idx_d   = idx_q + ADDR_W'(1);
        if (&idx_q) state_d = ST_IDLE;
      end
      ST_IDLE: begin
        if (lk_fire) begin
          en_c   = 1'b1;
          addr_c = lk_addr;
        end else if (!fifo_empty) begin
          en_c    = 1'b1;
          addr_c  = head_addr;
          state_d = ST_RD;
        end
      end
      ST_RD: state_d = ST_WR;
      ST_WR: begin
        en_c    = 1'b1;
        we_c    = 1'b1;
        addr_c  = head_addr;
        wdata_c = ctr_next(rmw_q, head_taken);
        state_d = ST_IDLE;
      end
      default: state_d = ST_INIT;
    endcase
  end

  // The table port stays quiet while reset is held, even though the FSM
  // already sits on the first sweep write.
  assign tbl_en    = rst && en_c;
  assign tbl_we    = rst && we_c;
  assign tbl_addr  = rst ? addr_c  : '0;
  assign tbl_wdata = rst ? wdata_c : '0;

  // FSM, sweep index, RMW read capture and lookup-response flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_INIT;
      idx_q        <= '0;
      rmw_q        <= '0;
      pred_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pred_valid_q <= lk_fire;
      if (state_q == ST_RD) rmw_q <= tbl_rdata;
    end
  end

  assign pred_valid = pred_valid_q;
  assign pred_state = pred_valid_q ? tbl_rdata : 2'b00;

`ifdef BHT_BYPASS_EN
  logic byp_hit, byp_taken;
  logic byp_hit_q, byp_taken_q;

  // Youngest queued update to the lookup index, oldest entry scanned first;
  // a push in the same cycle is younger than anything already stored.
  always_comb begin
    byp_hit   = 1'b0;
    byp_taken = 1'b0;
    for (int k = 0; k < FIFO_DEPTH; k++) begin
      if (k < int'(fifo_count) &&
          fifo_mem[fifo_rd_ptr + PTR_W'(k)][ADDR_W:1] == lk_addr) begin
        byp_hit   = 1'b1;
        byp_taken = fifo_mem[fifo_rd_ptr + PTR_W'(k)][0];
      end
    end
    if (push && upd_addr == lk_addr) begin
      byp_hit   = 1'b1;
      byp_taken = upd_taken;
    end
  end

  // Bypass result captured at lookup acceptance for use in the next cycle
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      byp_hit_q   <= 1'b0;
      byp_taken_q <= 1'b0;
    end else begin
      byp_hit_q   <= lk_fire && byp_hit;
      byp_taken_q <= byp_taken;
    end
  end

  assign pred_taken = (pred_valid_q && byp_hit_q) ? byp_taken_q : pred_state[1];
`else
  assign pred_taken = pred_state[1];
`endif

endmodule

// File: tb/tb_bht_update_scheduler.sv
// Self-checking bench for bht_update_scheduler: behavioural single-port
// table model, scoreboard queues for expected table writes and lookup
// responses, and one task per scenario.
module tb_bht_update_scheduler;

  localparam int ADDR_W = 8;
`ifdef BHT_BYPASS_EN
  localparam logic BYP_EXP = 1'b0;
`else
  localparam logic BYP_EXP = 1'b1;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              lk_valid = 1'b0;
  logic [ADDR_W-1:0] lk_addr = '0;
  logic              lk_ready;
  logic              pred_valid, pred_taken;
  logic [1:0]        pred_state;
  logic              upd_valid = 1'b0;
  logic [ADDR_W-1:0] upd_addr = '0;
  logic              upd_taken = 1'b0;
  logic              upd_ready, busy;
  logic              tbl_en, tbl_we;
  logic [ADDR_W-1:0] tbl_addr;
  logic [1:0]        tbl_wdata, tbl_rdata;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bht_update_scheduler #(
    .ADDR_W(ADDR_W), .FIFO_DEPTH(4), .INIT_STATE(2'b11)
  ) dut (
    .clk(clk), .rst(rst),
    .lk_valid(lk_valid), .lk_addr(lk_addr), .lk_ready(lk_ready),
    .pred_valid(pred_valid), .pred_taken(pred_taken), .pred_state(pred_state),
    .upd_valid(upd_valid), .upd_addr(upd_addr), .upd_taken(upd_taken),
    .upd_ready(upd_ready), .busy(busy),
    .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
    .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
  );

  // Single-port table: read data appears one cycle after the read and holds
  logic [1:0] ram [256];
  logic [1:0] ram_rdata = 2'b00;
  initial for (int i = 0; i < 256; i++) ram[i] = 2'b00;
  always @(posedge clk) begin
    if (tbl_en) begin
      if (tbl_we) ram[tbl_addr] <= tbl_wdata;
      else        ram_rdata     <= ram[tbl_addr];
    end
  end
  assign tbl_rdata = ram_rdata;

  // Scoreboard state
  typedef struct packed { logic [7:0] addr; logic [1:0] wdata; logic taken; } wr_t;
  typedef struct packed { logic [7:0] addr; logic [1:0] state; logic taken; } pd_t;
  wr_t        wr_q[$];
  pd_t        pd_q[$];
  logic [1:0] exp_tbl   [256];  // value once every pushed update is applied
  logic [1:0] committed [256];  // value after writes already seen
  wr_t        mon_wr;
  pd_t        mon_pd;

  function automatic logic [1:0] sat_model(logic [1:0] v, logic t);
    if (t) return (v == 2'b11) ? 2'b11 : v + 2'b01;
    return (v == 2'b00) ? 2'b00 : v - 2'b01;
  endfunction

  task automatic reset_models();
    for (int i = 0; i < 256; i++) begin
      exp_tbl[i]   = 2'b11;
      committed[i] = 2'b11;
    end
    wr_q.delete();
    pd_q.delete();
  endtask

  // Monitor: compare responses/writes, then record new requests
  always @(negedge clk) begin
    if (rst) begin
      if (pred_valid) begin
        checks++;
        if (pd_q.size() == 0) begin
          errors++;
          $display("FAIL pred_unexpected: got state=%b taken=%b, none required", pred_state, pred_taken);
        end else begin
          mon_pd = pd_q.pop_front();
          if ({pred_state, pred_taken} !== {mon_pd.state, mon_pd.taken}) begin
            errors++;
            $display("FAIL pred_%02h: got state=%b taken=%b, need state=%b taken=%b",
                     mon_pd.addr, pred_state, pred_taken, mon_pd.state, mon_pd.taken);
          end
        end
      end
      if (tbl_en && tbl_we && !busy) begin
        checks++;
        if (wr_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr=%02h data=%b, none required", tbl_addr, tbl_wdata);
        end else begin
          mon_wr = wr_q.pop_front();
          committed[mon_wr.addr] = mon_wr.wdata;
          if ({tbl_addr, tbl_wdata} !== {mon_wr.addr, mon_wr.wdata}) begin
            errors++;
            $display("FAIL write: got addr=%02h data=%b, need addr=%02h data=%b",
                     tbl_addr, tbl_wdata, mon_wr.addr, mon_wr.wdata);
          end
        end
      end
      if (upd_valid && upd_ready) begin
        mon_wr.addr  = upd_addr;
        mon_wr.taken = upd_taken;
        mon_wr.wdata = sat_model(exp_tbl[upd_addr], upd_taken);
        exp_tbl[upd_addr] = mon_wr.wdata;
        wr_q.push_back(mon_wr);
      end
      if (lk_valid && lk_ready) begin
        mon_pd.addr  = lk_addr;
        mon_pd.state = committed[lk_addr];
        mon_pd.taken = committed[lk_addr][1];
`ifdef BHT_BYPASS_EN
        foreach (wr_q[i]) if (wr_q[i].addr == lk_addr) mon_pd.taken = wr_q[i].taken;
`endif
        pd_q.push_back(mon_pd);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lookup(input logic [7:0] a);
    int n = 0;
    tick();
    lk_valid = 1'b1;
    lk_addr  = a;
    @(negedge clk);
    while (!lk_ready && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (!lk_ready) begin
      errors++;
      $display("FAIL lookup_accept_%02h: lk_ready=%b after %0d cycles, need 1", a, lk_ready, n);
    end
    tick();
    lk_valid = 1'b0;
  endtask

  task automatic update(input logic [7:0] a, input logic t);
    int n = 0;
    tick();
    upd_valid = 1'b1;
    upd_addr  = a;
    upd_taken = t;
    @(negedge clk);
    while (!upd_ready && n < 40) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (!upd_ready) begin
      errors++;
      $display("FAIL update_accept_%02h: upd_ready=%b after %0d cycles, need 1", a, upd_ready, n);
    end
    tick();
    upd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (wr_q.size() != 0 && n < 64) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (wr_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d updates still pending, need 0", wr_q.size());
    end
    tick();
  endtask

  task automatic check_pred(input string name, input logic [1:0] st, input logic tk);
    @(negedge clk);
    checks++;
    if ({pred_valid, pred_state, pred_taken} !== {1'b1, st, tk}) begin
      errors++;
      $display("FAIL %s: got valid=%b state=%b taken=%b, need valid=1 state=%b taken=%b",
               name, pred_valid, pred_state, pred_taken, st, tk);
    end
  endtask

  task automatic test_reset();
    int sweep_ok = 0;
    #2 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({pred_valid, pred_taken, pred_state, lk_ready, upd_ready, busy} !== 7'b0000001) begin
      errors++;
      $display("FAIL reset_ctrl: got pv=%b pt=%b ps=%b lr=%b ur=%b busy=%b, need 0 0 00 0 0 1",
               pred_valid, pred_taken, pred_state, lk_ready, upd_ready, busy);
    end
    checks++;
    if ({tbl_en, tbl_we, tbl_addr, tbl_wdata} !== 12'h000) begin
      errors++;
      $display("FAIL reset_tbl: got en=%b we=%b addr=%02h wdata=%b, need all zero",
               tbl_en, tbl_we, tbl_addr, tbl_wdata);
    end
    reset_models();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (busy && tbl_en && tbl_we && tbl_addr == 8'(i) && tbl_wdata == 2'b11) sweep_ok++;
    end
    checks++;
    if (sweep_ok !== 256) begin
      errors++;
      $display("FAIL init_sweep: got %0d correct sweep writes, need 256", sweep_ok);
    end
    @(negedge clk);
    checks++;
    if ({busy, lk_ready, upd_ready} !== 3'b011) begin
      errors++;
      $display("FAIL init_done: got busy=%b lk_ready=%b upd_ready=%b, need 0 1 1", busy, lk_ready, upd_ready);
    end
    lookup(8'h05);
    check_pred("lookup_05", 2'b11, 1'b1);
  endtask

  task automatic test_not_taken();
    update(8'h10, 1'b0);
    update(8'h10, 1'b0);
    wait_drain();
    lookup(8'h10);
    check_pred("lookup_10", 2'b01, 1'b0);
  endtask

  task automatic test_back_to_back();
    logic [3:0] lr_seen = '0, ur_seen = '0;
    int npush = 0, guard = 0;
    tick();
    lk_valid  = 1'b1;
    lk_addr   = 8'h05;
    upd_valid = 1'b1;
    upd_addr  = 8'h40;
    upd_taken = 1'b0;
    while (npush < 4 && guard < 20) begin
      @(negedge clk);
      if (upd_valid && upd_ready) npush++;
      tick();
      guard++;
      lk_addr   = 8'h05 + 8'(guard % 3);
      upd_addr  = 8'h40 + 8'(npush);
      upd_taken = npush[0];
      if (npush >= 4) upd_valid = 1'b0;
    end
    for (int i = 3; i >= 0; i--) begin
      @(negedge clk);
      lr_seen[i] = lk_ready;
      ur_seen[i] = upd_ready;
      tick();
      lk_addr = 8'h06;
    end
    checks++;
    if (lr_seen !== 4'b0001) begin
      errors++;
      $display("FAIL starve_lk_ready: got %b, need 0001", lr_seen);
    end
    checks++;
    if (ur_seen !== 4'b0011) begin
      errors++;
      $display("FAIL starve_upd_ready: got %b, need 0011", ur_seen);
    end
    repeat (3) tick();
    lk_valid = 1'b0;
    wait_drain();
  endtask

  task automatic test_saturation();
    repeat (3) update(8'h50, 1'b1);
    repeat (5) update(8'h50, 1'b0);
    wait_drain();
    lookup(8'h50);
    check_pred("lookup_50_sat", 2'b00, 1'b0);
  endtask

  task automatic test_reset_mid_rmw();
    int n = 0;
    update(8'h20, 1'b0);
    @(negedge clk);
    while (!(tbl_en && !tbl_we && tbl_addr == 8'h20) && n < 20) begin
      tick();
      @(negedge clk);
      n++;
    end
    checks++;
    if (!(tbl_en && !tbl_we && tbl_addr == 8'h20)) begin
      errors++;
      $display("FAIL rmw_read_20: no read of 20 within %0d cycles", n);
    end
    tick();
    rst = 1'b0;
    reset_models();
    tick();
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({busy, tbl_we, tbl_addr} !== {1'b1, 1'b1, 8'h00}) begin
      errors++;
      $display("FAIL reinit_start: got busy=%b we=%b addr=%02h, need 1 1 00", busy, tbl_we, tbl_addr);
    end
    n = 0;
    while (busy && n < 300) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL reinit_done: busy=%b after %0d cycles, need 0", busy, n);
    end
    lookup(8'h20);
    check_pred("lookup_20_after_reset", 2'b11, 1'b1);
  endtask

  task automatic test_bypass();
    tick();
    lk_valid  = 1'b1;
    lk_addr   = 8'h31;
    upd_valid = 1'b1;
    upd_addr  = 8'h30;
    upd_taken = 1'b0;
    @(negedge clk);
    tick();
    upd_valid = 1'b0;
    lk_addr   = 8'h30;
    @(negedge clk);
    checks++;
    if (lk_ready !== 1'b1) begin
      errors++;
      $display("FAIL bypass_accept_30: lk_ready=%b, need 1", lk_ready);
    end
    tick();
    lk_addr   = 8'h32;
    upd_valid = 1'b1;
    upd_addr  = 8'h32;
    upd_taken = 1'b0;
    check_pred("bypass_30", 2'b11, BYP_EXP);
    checks++;
    if ({lk_ready, upd_ready} !== 2'b11) begin
      errors++;
      $display("FAIL bypass_same_cycle_accept: lk_ready=%b upd_ready=%b, need 1 1", lk_ready, upd_ready);
    end
    tick();
    upd_valid = 1'b0;
    lk_addr   = 8'h33;
    check_pred("bypass_32_same_cycle", 2'b11, BYP_EXP);
    tick();
    lk_valid = 1'b0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_not_taken();
    test_back_to_back();
    test_saturation();
    test_reset_mid_rmw();
    test_bypass();
    repeat (4) tick();
    checks++;
    if (pd_q.size() != 0) begin
      errors++;
      $display("FAIL pred_pending: %0d lookups without response, need 0", pd_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/bht_update_scheduler.md
# bht_update_scheduler

Controller that owns the single-port 256-entry 2-bit branch history table array and schedules all accesses to it. Fetch-stage lookups get priority; resolved-branch updates from execute are buffered in a small FIFO and applied as read-modify-write sequences in cycles with no lookup. After reset it sweeps the array to a known state before accepting traffic. It sits between the fetch predictor path, the execute resolution path and the BHT storage.

## Interface
- ADDR_W, 8, table index width; the table has 2^ADDR_W entries
- FIFO_DEPTH, 4, update queue depth; must be a power of two and at least 2
- INIT_STATE, 2'b11, counter value written to every entry by the init sweep
- clk  in  1  clock; all logic on the rising edge
- rst  in  1  asynchronous, active-low reset
- lk_valid  in  1  fetch lookup request
- lk_addr  in  ADDR_W  lookup index
- lk_ready  out  1  lookup accepted this cycle when lk_valid is also high
- pred_valid  out  1  prediction result valid
- pred_taken  out  1  predicted direction
- pred_state  out  2  raw counter read
- upd_valid  in  1  resolved branch update
- upd_addr  in  ADDR_W  update index
- upd_taken  in  1  resolved direction
- upd_ready  out  1  FIFO not full
- busy  out  1  init sweep in progress
- tbl_en, tbl_we  out  1  array access enable and write enable
- tbl_addr  out  ADDR_W  array index
- tbl_wdata  out  2  array write data
- tbl_rdata  in  2  array read data, valid one cycle after a read with tbl_en=1 and tbl_we=0

## Operation
- FSM states: INIT, IDLE, RD, WR. On reset the FSM enters INIT with the sweep index at 0.
- INIT: writes INIT_STATE to index 0..2^ADDR_W-1, one entry per cycle; busy=1, lk_ready=0, upd_ready=0. After the last index is written it moves to IDLE.
- IDLE: lk_ready=1 unless the FIFO is full. An accepted lookup issues a table read at lk_addr. If no lookup is accepted, the FIFO is non-empty, and no lookup is pending, the FSM issues a read at the FIFO head address and moves to RD.
- RD: this is a one-cycle wait state and lk_ready=0. The next state is WR.
- WR: computes the next counter value from tbl_rdata and the head's taken bit, and writes it. Taken increments and saturates at 11; not-taken decrements and saturates at 00. The FIFO pops in this cycle and lk_ready=0. The FSM then returns to IDLE.
- Starvation rule: when the FIFO is full, lk_ready=0, so the RMW sequence always wins.
- Prediction: pred_taken = pred_state[1].
- FIFO push happens on upd_valid & upd_ready. A push in the same cycle as a WR pop is allowed when the FIFO is full, because upd_ready already reflects that cycle's pop.
- Updates to the same index are applied in arrival order. A write always completes before the next RMW read is issued.

## Timing
- Lookup accepted in cycle N gives pred_valid=1 in cycle N+1, with data taken from tbl_rdata.
- Back-to-back lookups sustain one per cycle.
- RMW takes 3 cycles from the IDLE read to the WR write, and the minimum spacing between consecutive updates is 3 cycles.
- Init sweep takes 2^ADDR_W cycles; busy falls in the cycle after the last write.
- Reset values: pred_valid=0, pred_taken=0, pred_state=00, lk_ready=0, upd_ready=0, busy=1, tbl_en=0, tbl_we=0, tbl_addr=0, tbl_wdata=0.
- Reset asserted mid-RMW or mid-sweep discards the FIFO contents and the in-flight update, then restarts INIT from index 0.
- pred_valid is never asserted in a cycle that follows INIT, RD or WR.

## Configuration
- BHT_BYPASS_EN defined: at lookup acceptance, the FIFO entries are searched for lk_addr. If any match, pred_taken in N+1 equals upd_taken of the youngest matching entry, which is captured at N. pred_state still reports the raw array value. A same-cycle push to a matching address is included in the search.
- BHT_BYPASS_EN undefined: pred_taken is always tbl_rdata[1], and no match logic is built.

## Structure
- Shared package holds the FSM state encoding and the counter encodings: STRONG_NT=00, WEAK_NT=01, WEAK_T=10, STRONG_T=11.
- Shared package also holds the saturating next-state function.
- Sub-module bht_upd_fifo implements the parameterised synchronous FIFO with full and empty flags. Under BHT_BYPASS_EN it also exposes its storage for the match search.

## Test plan
- Reset release: busy=1 for 256 cycles with writes of 11 to indices 0..255; busy falls, and a lookup at 0x05 in the next cycle gives pred_state=11, pred_taken=1.
- Two not-taken updates to 0x10 with no lookups: writes of 10 then 01 are seen on the table port, and a subsequent lookup at 0x10 returns pred_state=01, pred_taken=0.
- Lookups every cycle with 4 updates queued: upd_ready falls; lk_ready is then low for the RMW cycles and lookups resume after the WR cycle.
- Saturation: three taken updates to an entry holding 11 write 11 each time; four not-taken updates from 11 end at 00, and a fifth writes 00.
- Reset asserted during RD of an update to 0x20: no write to 0x20 is seen; INIT restarts from index 0 and 0x20 reads 11 afterwards.
- BHT_BYPASS_EN defined: queue not-taken to 0x30 while lookups hold off the drain, then look up 0x30; pred_taken=0 and pred_state=11. With the macro undefined, the same sequence gives pred_taken=1.
